tail_bits_sequencer: RTL

- Parametrised successor to the fixed 8-lane turbo tail-bit mux.
- Passes systematic and parity lanes (xk/zk/zk') from the two constituent encoders to the rate-matching side through a registered valid/ready stage.
- After the last data beat, stalls input, captures both trellis states and emits the 12 LTE termination bits (4 per stream) over ceil(4/LANES) beats.
- Flags last beat and valid bit count.

---
 rtl/tail_bits_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/tail_bits_sequencer.sv
// Turbo-encoder output stage: registers xk/zk/zk' lanes through a valid/ready
// slot, then appends the 12 LTE trellis-termination bits over ceil(4/LANES) beats.
module tail_bits_sequencer #(
  parameter int LANES = 8,
  parameter int NB_W  = $clog2(LANES + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [LANES-1:0] xk_in,
  input  logic [LANES-1:0] zk_in,
  input  logic [LANES-1:0] zk_prime_in,
  input  logic             q0,
  input  logic             q1,
  input  logic             q2,
  input  logic             q0_prime,
  input  logic             q1_prime,
  input  logic             q2_prime,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANES-1:0] xk_out,
  output logic [LANES-1:0] zk_out,
  output logic [LANES-1:0] zk_prime_out,
  output logic             out_tail,
  output logic             out_last,
  output logic [NB_W-1:0]  out_nbits
);

  localparam int         T         = (4 + LANES - 1) / LANES;
  localparam logic [2:0] LAST_BEAT = 3'(T - 1);

  typedef enum logic [1:0] {PASS, CAPTURE, TAIL} state_t;

  state_t     state;
  logic [3:0] tail_x, tail_z, tail_zp;
  logic [2:0] beat_cnt;
  logic       load_ok;
  logic [3:0] cap_x, cap_z, cap_zp;

  // Lane i of tail beat b carries tail index b*LANES+i; indices past 3 are zero.
  function automatic logic [LANES-1:0] tail_slice(input logic [3:0] bits,
                                                   input logic [2:0] beat);
    logic [LANES-1:0] s;
    logic [3:0]       sh;
    int               idx;
    s = '0;
    for (int i = 0; i < LANES; i++) begin
      idx = int'(beat) * LANES + i;
      sh  = bits >> idx;
      if (idx < 4) s[i] = sh[0];
    end
    return s;
  endfunction

  function automatic logic [NB_W-1:0] tail_nbits(input logic [2:0] beat);
    int rem;
    rem = 4 - int'(beat) * LANES;
    if (rem > LANES) rem = LANES;
    return NB_W'(rem);
  endfunction

  assign load_ok  = !out_valid || out_ready;
  assign in_ready = (state == PASS) && load_ok;

  // Bit k of each vector is tail index k of that stream.
  assign cap_x  = {q1_prime, q1_prime ^ q2_prime, q1, q1 ^ q2};
  assign cap_z  = {q0_prime, q0_prime ^ q2_prime, q0, q0 ^ q2};
  assign cap_zp = {q0_prime, q0_prime ^ q1_prime, q0, q0 ^ q1};

  // Output register stage (_p0): data beat or tail beat, held under backpressure
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= PASS;
      out_valid    <= 1'b0;
      xk_out       <= '0;
      zk_out       <= '0;
      zk_prime_out <= '0;
      out_tail     <= 1'b0;
      out_last     <= 1'b0;
      out_nbits    <= '0;
      tail_x       <= '0;
      tail_z       <= '0;
      tail_zp      <= '0;
      beat_cnt     <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        PASS: begin
          if (in_valid && load_ok) begin
            out_valid    <= 1'b1;
            xk_out       <= xk_in;
            zk_out       <= zk_in;
            zk_prime_out <= zk_prime_in;
            out_tail     <= 1'b0;
            out_last     <= 1'b0;
            out_nbits    <= NB_W'(LANES);
            if (in_last) state <= CAPTURE;
          end
        end
        CAPTURE: begin
          // Encoder is stalled here, so q is sampled exactly at the load edge.
          if (load_ok) begin
            tail_x       <= cap_x;
            tail_z       <= cap_z;
            tail_zp      <= cap_zp;
            out_valid    <= 1'b1;
            xk_out       <= tail_slice(cap_x, 3'd0);
            zk_out       <= tail_slice(cap_z, 3'd0);
            zk_prime_out <= tail_slice(cap_zp, 3'd0);
            out_tail     <= 1'b1;
            out_last     <= (T == 1);
            out_nbits    <= tail_nbits(3'd0);
            if (T == 1) begin
              state <= PASS;
            end else begin
              state    <= TAIL;
              beat_cnt <= 3'd1;
            end
          end
        end
        TAIL: begin
          if (load_ok) begin
            out_valid    <= 1'b1;
            xk_out       <= tail_slice(tail_x, beat_cnt);
            zk_out       <= tail_slice(tail_z, beat_cnt);
            zk_prime_out <= tail_slice(tail_zp, beat_cnt);
            out_tail     <= 1'b1;
            out_last     <= (beat_cnt == LAST_BEAT);
            out_nbits    <= tail_nbits(beat_cnt);
            if (beat_cnt == LAST_BEAT) begin
              state    <= PASS;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 3'd1;
            end
          end
        end
        default: state <= PASS;
      endcase
    end
  end

endmodule
